// File: rtl/miriscv_pkg.sv
// Shared definitions for the miriscv instruction-memory loader.
// Holds the IM window constants and the loader FSM state encoding.
package miriscv_pkg;

  // Byte address of IM word 0.
  localparam logic [31:0] IM_BASE_ADDR   = 32'h7600_0000;
  // IM capacity in 32-bit words; also the largest accepted image length.
  localparam int unsigned IM_DEPTH_WORDS = 64;

  // Loader session states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN0  = 3'd1,
    ST_LEN1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } loader_state_e;

endpackage

// File: rtl/miriscv_byte_packer.sv
// Assembles four little-endian stream bytes into one 32-bit word.
// Ports:
//   clk_i, rst_n_i  clock and synchronous active-low reset
//   clr_i           restart assembly at byte 0 (session start)
//   take_i          a stream byte transfers this cycle
//   byte_i          the byte being transferred
//   word_o          word including the byte taken this cycle
//   word_full_o     high when the 4th byte of a word is taken this cycle
module miriscv_byte_packer (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        clr_i,
  input  logic        take_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);

  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] word_q, word_d;

  // Insert the incoming byte at lane byte_cnt; the counter wraps to 0 after lane 3.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    if (clr_i) begin
      byte_cnt_d = 2'd0;
      word_d     = 32'd0;
    end else if (take_i) begin
      word_d[{byte_cnt_q, 3'b000} +: 8] = byte_i;
      byte_cnt_d                        = byte_cnt_q + 2'd1;
    end else begin
      byte_cnt_d = byte_cnt_q;
    end
  end

  // Byte counter and assembly register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      byte_cnt_q <= 2'd0;
      word_q     <= 32'd0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
    end
  end

  // The combinational view lets the loader latch the full word on the 4th byte edge.
  assign word_o      = word_d;
  assign word_full_o = take_i && !clr_i && (byte_cnt_q == 2'd3);

endmodule

// File: rtl/miriscv_im_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory.
// Stream: len[7:0], len[15:8], then 4*len data bytes; one IM write per word.
// Ports:
//   clk_i, rst_n_i     clock and synchronous active-low reset
//   start_i            begin a session (honoured in IDLE/DONE/ERR only)
//   byte_i/_valid_i    stream byte and its valid
//   byte_ready_o       loader accepts a byte (LEN0/LEN1/DATA)
//   we_o/waddr_o/wdata_o  registered IM write port
//   busy_o             session in progress; keeps the core held
//   done_o, err_o      sticky completion / length-error flags
module miriscv_im_loader
  import miriscv_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = IM_BASE_ADDR,
  parameter int unsigned DEPTH_WORDS = IM_DEPTH_WORDS
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic        we_o,
  output logic [31:0] waddr_o,
  output logic [31:0] wdata_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS) + 1;
  localparam logic [15:0] DEPTH_LEN = 16'(DEPTH_WORDS);

  loader_state_e state_q, state_d;
  logic [15:0]      len_q, len_d;
  logic [IDX_W-1:0] word_idx_q, word_idx_d;
  logic [31:0]      waddr_q, waddr_d, wdata_q, wdata_d;
  logic             ready_q, ready_d, we_q, we_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic        xfer_s;
  logic        pk_clr_s, pk_take_s, pk_full_s;
  logic [31:0] pk_word_s;
  logic [15:0] len_full_s;

  assign xfer_s     = byte_valid_i && ready_q;
  assign len_full_s = {byte_i, len_q[7:0]};
  assign pk_take_s  = (state_q == ST_DATA) && xfer_s;

  miriscv_byte_packer u_packer (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .clr_i       (pk_clr_s),
    .take_i      (pk_take_s),
    .byte_i      (byte_i),
    .word_o      (pk_word_s),
    .word_full_o (pk_full_s)
  );

  // Next-state logic; outputs are registered from the next state so they line up with it.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    pk_clr_s   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_i) begin
          state_d = ST_LEN0;
        end else begin
          state_d = state_q;
        end
      end
      ST_LEN0: begin
        if (xfer_s) begin
          len_d[7:0] = byte_i;
          state_d    = ST_LEN1;
        end else begin
          state_d = ST_LEN0;
        end
      end
      ST_LEN1: begin
        if (xfer_s) begin
          len_d      = len_full_s;
          word_idx_d = '0;
          pk_clr_s   = 1'b1;
          if (len_full_s == 16'd0) begin
            state_d = ST_DONE;
          end else if (len_full_s > DEPTH_LEN) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_LEN1;
        end
      end
      ST_DATA: begin
        if (pk_full_s) begin
          state_d = ST_WRITE;
          waddr_d = BASE_ADDR + 32'({word_idx_q, 2'b00});
          wdata_d = pk_word_s;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_WRITE: begin
        word_idx_d = word_idx_q + 1'b1;
        if ((16'(word_idx_q) + 16'd1) == len_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DATA;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_LEN0) || (state_d == ST_LEN1) || (state_d == ST_DATA);
    busy_d  = ready_d || (state_d == ST_WRITE);
    we_d    = (state_d == ST_WRITE);
    done_d  = (state_d == ST_DONE);
    err_d   = (state_d == ST_ERR);
  end

  // State and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      len_q      <= 16'd0;
      word_idx_q <= '0;
      waddr_q    <= BASE_ADDR;
      wdata_q    <= 32'd0;
      ready_q    <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      ready_q    <= ready_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign byte_ready_o = ready_q;
  assign we_o         = we_q;
  assign waddr_o      = waddr_q;
  assign wdata_o      = wdata_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_miriscv_im_loader.sv
// Scoreboard bench for miriscv_im_loader: stimulus pushes expected writes,
// a negedge monitor pops and compares each we_o pulse.
module tb_miriscv_im_loader;

  localparam logic [31:0] BASE = 32'h7600_0000;

  logic        clk = 1'b0;
  logic        rst_n_i, start_i, byte_valid_i;
  logic [7:0]  byte_i;
  logic        byte_ready_o, we_o, busy_o, done_o, err_o;
  logic [31:0] waddr_o, wdata_o;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  failures = 0;
  int  wr_cnt = 0;
  int  rdy_low_cnt = 0;

  always #5 clk = ~clk;

  miriscv_im_loader dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n_i),
    .start_i      (start_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .we_o         (we_o),
    .waddr_o      (waddr_o),
    .wdata_o      (wdata_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n_i === 1'b1 && busy_o === 1'b1 && byte_ready_o === 1'b0) rdy_low_cnt++;
    if (we_o === 1'b1) begin
      wr_cnt++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_we actual addr=%h data=%h expected no write", waddr_o, wdata_o);
      end else begin
        e = sb.pop_front();
        chk("we_addr", waddr_o, e.a);
        chk("we_data", wdata_o, e.d);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    byte_i = b;
    byte_valid_i = 1'b1;
    while (1) begin
      @(negedge clk);
      if (byte_ready_o) break;
      n++;
      if (n > 40) begin
        checks++;
        failures++;
        $display("FAIL send_byte_timeout actual ready=0 expected ready within 40 cycles");
        break;
      end
    end
    tick();
  endtask

  task automatic idle_gap(input int n, input bit pulse_start);
    byte_valid_i = 1'b0;
    repeat (n) begin
      start_i = pulse_start;
      tick();
      start_i = 1'b0;
    end
  endtask

  task automatic send_word(input logic [31:0] addr, input logic [31:0] w,
                           input int gap_max, input bit pulse);
    sb.push_back('{a: addr, d: w});
    for (int k = 0; k < 4; k++) begin
      if (gap_max > 0) idle_gap($urandom_range(gap_max, 0), pulse);
      send_byte(w[8*k +: 8]);
    end
  endtask

  task automatic start_session(input logic [15:0] len);
    byte_valid_i = 1'b0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    send_byte(len[7:0]);
    send_byte(len[15:8]);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, done_o}, 32'd1);
  endtask

  task automatic run_two(input int gap, input bit pulse, input string name);
    start_session(16'd2);
    if (pulse) begin
      byte_valid_i = 1'b0;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
    end
    send_word(BASE,          32'h0000_0013, gap, pulse);
    send_word(BASE + 32'd4,  32'h0010_0093, gap, pulse);
    byte_valid_i = 1'b0;
    wait_done(name);
    chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    chk({name, "_waddr_hold"}, waddr_o, BASE + 32'd4);
    chk({name, "_wdata_hold"}, wdata_o, 32'h0010_0093);
    chk({name, "_err"}, {31'd0, err_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0, rl0;
    logic [31:0] w;
    rst_n_i = 1'b0;
    start_i = 1'b0;
    byte_valid_i = 1'b0;
    byte_i = 8'h00;

    // 1: reset with random inputs
    repeat (3) begin
      start_i = 1'($urandom);
      byte_valid_i = 1'($urandom);
      byte_i = 8'($urandom);
      tick();
      @(negedge clk);
      chk("rst_ready", {31'd0, byte_ready_o}, 32'd0);
      chk("rst_we",    {31'd0, we_o}, 32'd0);
      chk("rst_waddr", waddr_o, BASE);
      chk("rst_wdata", wdata_o, 32'd0);
      chk("rst_busy",  {31'd0, busy_o}, 32'd0);
      chk("rst_done",  {31'd0, done_o}, 32'd0);
      chk("rst_err",   {31'd0, err_o}, 32'd0);
    end
    start_i = 1'b0;
    byte_valid_i = 1'b0;
    tick();
    rst_n_i = 1'b1;
    tick();

    // 2: two-word image, valid held high
    run_two(0, 1'b0, "s2");

    // 3: full-depth image
    wr0 = wr_cnt;
    rl0 = rdy_low_cnt;
    start_session(16'd64);
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      send_word(BASE + 32'(4 * i), w, 0, 1'b0);
    end
    byte_valid_i = 1'b0;
    wait_done("s3_done");
    chk("s3_writes", 32'(wr_cnt - wr0), 32'd64);
    chk("s3_ready_low_cycles", 32'(rdy_low_cnt - rl0), 32'd64);
    chk("s3_last_addr", waddr_o, 32'h7600_00FC);
    chk("s3_sb_empty", 32'(sb.size()), 32'd0);

    // 4: oversize length, then empty image
    wr0 = wr_cnt;
    start_session(16'd65);
    byte_i = 8'hAA;
    byte_valid_i = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("s4_err",   {31'd0, err_o}, 32'd1);
    chk("s4_ready", {31'd0, byte_ready_o}, 32'd0);
    chk("s4_busy",  {31'd0, busy_o}, 32'd0);
    chk("s4_done",  {31'd0, done_o}, 32'd0);
    tick();
    start_session(16'd0);
    byte_valid_i = 1'b0;
    wait_done("s4_len0_done");
    chk("s4_len0_err", {31'd0, err_o}, 32'd0);
    chk("s4_no_writes", 32'(wr_cnt - wr0), 32'd0);

    // 5: reset mid-word, then a clean session
    wr0 = wr_cnt;
    start_session(16'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    byte_valid_i = 1'b0;
    rst_n_i = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("s5_rst_busy",  {31'd0, busy_o}, 32'd0);
    chk("s5_rst_ready", {31'd0, byte_ready_o}, 32'd0);
    chk("s5_rst_waddr", waddr_o, BASE);
    rst_n_i = 1'b1;
    repeat (6) tick();
    chk("s5_no_writes", 32'(wr_cnt - wr0), 32'd0);
    run_two(0, 1'b0, "s5");

    // 6: random valid gaps with start pulses mid-load
    run_two(3, 1'b1, "s6");

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
